// File: rtl/pair_judge.sv
// Two-player memory-game referee: tracks two revealed cells, holds them face-up
// for SHOW_CYCLES cycles, then scores the pair and hands the turn over on a miss.
module pair_judge #(
  parameter int SHOW_CYCLES = 4,
  parameter int PAIRS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  input  logic [3:0]  sel_label,
  output logic        busy,
  output logic [15:0] reveal_mask,
  output logic [15:0] matched_mask,
  output logic        res_valid,
  output logic        res_match,
  output logic        player,
  output logic [3:0]  score_j1,
  output logic [3:0]  score_j2,
  output logic        finish
);

  // state   | meaning
  // IDLE    | waiting for the first cell (A)
  // ONE     | A revealed, waiting for the second cell (B)
  // SHOW    | A and B held face-up while the down-counter runs out
  // RESOLVE | one-cycle result pulse; scores/masks already updated
  // DONE    | every pair found, locked until reset
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ONE     = 3'd1;
  localparam logic [2:0] SHOW    = 3'd2;
  localparam logic [2:0] RESOLVE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [7:0] SHOW_LOAD = 8'(SHOW_CYCLES - 1);
  localparam logic [4:0] PAIRS_W   = 5'(PAIRS);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [3:0] idx_a, lbl_a, idx_b, lbl_b;
  logic [4:0] total;
  logic       sel_open;
  logic       same;

  assign sel_open = sel_valid && !matched_mask[sel_idx];
  assign same     = (lbl_a == lbl_b);
  assign total    = {1'b0, score_j1} + {1'b0, score_j2};
  assign busy     = (state == SHOW) || (state == RESOLVE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_a        <= '0;
      lbl_a        <= '0;
      idx_b        <= '0;
      lbl_b        <= '0;
      reveal_mask  <= '0;
      matched_mask <= '0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      player       <= 1'b0;
      score_j1     <= '0;
      score_j2     <= '0;
      finish       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      res_match <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_open) begin
            idx_a                <= sel_idx;
            lbl_a                <= sel_label;
            reveal_mask[sel_idx] <= 1'b1;
            state                <= ONE;
          end
        end
        ONE: begin
          if (sel_open && (sel_idx != idx_a)) begin
            idx_b                <= sel_idx;
            lbl_b                <= sel_label;
            reveal_mask[sel_idx] <= 1'b1;
            cnt                  <= SHOW_LOAD;
            state                <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == 8'd0) begin
            // Results are registered on entry so they are visible with res_valid.
            res_valid          <= 1'b1;
            res_match          <= same;
            reveal_mask[idx_a] <= 1'b0;
            reveal_mask[idx_b] <= 1'b0;
            if (same) begin
              matched_mask[idx_a] <= 1'b1;
              matched_mask[idx_b] <= 1'b1;
              if (player) score_j2 <= score_j2 + 4'd1;
              else        score_j1 <= score_j1 + 4'd1;
            end else begin
              player <= ~player;
            end
            state <= RESOLVE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESOLVE: begin
          if (total == PAIRS_W) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_judge.sv
// Directed bench for pair_judge: hand-computed expectations checked with
// immediate assertions after each step, sampled on the falling edge.
module tb_pair_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [3:0]  sel_label;
  logic        busy;
  logic [15:0] reveal_mask;
  logic [15:0] matched_mask;
  logic        res_valid;
  logic        res_match;
  logic        player;
  logic [3:0]  score_j1;
  logic [3:0]  score_j2;
  logic        finish;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pair_judge #(.SHOW_CYCLES(4), .PAIRS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .sel_label    (sel_label),
    .busy         (busy),
    .reveal_mask  (reveal_mask),
    .matched_mask (matched_mask),
    .res_valid    (res_valid),
    .res_match    (res_match),
    .player       (player),
    .score_j1     (score_j1),
    .score_j2     (score_j2),
    .finish       (finish)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sel_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One-cycle selection pulse; returns at the falling edge after it was sampled.
  task automatic pick(input logic [3:0] idx, input logic [3:0] lbl);
    sel_valid = 1'b1;
    sel_idx   = idx;
    sel_label = lbl;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  // A then B, then run out the remaining SHOW cycles; ends inside RESOLVE.
  task automatic play(input logic [3:0] a, input logic [3:0] la,
                      input logic [3:0] b, input logic [3:0] lb);
    pick(a, la);
    pick(b, lb);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    sel_idx   = '0;
    sel_label = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_busy",    16'(busy), 16'd0);
    check("rst_reveal",  reveal_mask, 16'h0000);
    check("rst_matched", matched_mask, 16'h0000);
    check("rst_finish",  16'(finish), 16'd0);

    // Matching pair 0/13
    pick(4'd0, 4'd1);
    check("lat_reveal_a", reveal_mask, 16'h0001);
    check("one_busy",     16'(busy), 16'd0);
    pick(4'd13, 4'd1);
    check("show_reveal",  reveal_mask, 16'h2001);
    check("show_busy",    16'(busy), 16'd1);
    repeat (3) @(negedge clk);
    check("show_last_no_res", 16'(res_valid), 16'd0);
    @(negedge clk);
    check("m_res_valid", 16'(res_valid), 16'd1);
    check("m_res_match", 16'(res_match), 16'd1);
    check("m_matched",   matched_mask, 16'h2001);
    check("m_score_j1",  16'(score_j1), 16'd1);
    check("m_player",    16'(player), 16'd0);
    check("m_reveal",    reveal_mask, 16'h0000);
    @(negedge clk);
    check("m_after_res", 16'(res_valid), 16'd0);
    check("m_after_busy", 16'(busy), 16'd0);

    // Mismatch 0/1 from a clean board
    do_reset();
    play(4'd0, 4'd1, 4'd1, 4'd3);
    check("x_res_valid", 16'(res_valid), 16'd1);
    check("x_res_match", 16'(res_match), 16'd0);
    check("x_player",    16'(player), 16'd1);
    check("x_reveal",    reveal_mask, 16'h0000);
    check("x_scores",    {8'd0, score_j1, score_j2}, 16'h0000);
    check("x_matched",   matched_mask, 16'h0000);
    @(negedge clk);

    // J2 now matches 0/13
    play(4'd0, 4'd1, 4'd13, 4'd1);
    check("j2_score", 16'(score_j2), 16'd1);
    check("j2_player", 16'(player), 16'd1);
    @(negedge clk);

    // Re-pick A and a matched cell while in ONE: both ignored
    pick(4'd5, 4'd2);
    pick(4'd5, 4'd2);
    pick(4'd0, 4'd1);
    check("one_ign_reveal", reveal_mask, 16'h0020);
    check("one_ign_busy",   16'(busy), 16'd0);

    // Selection during SHOW ignored
    pick(4'd6, 4'd2);
    pick(4'd7, 4'd9);
    check("show_ign_busy",   16'(busy), 16'd1);
    check("show_ign_reveal", reveal_mask, 16'h0060);
    repeat (3) @(negedge clk);
    check("s_res_valid", 16'(res_valid), 16'd1);
    check("s_matched",   matched_mask, 16'h2061);
    check("s_score_j2",  16'(score_j2), 16'd2);
    @(negedge clk);

    // Full game: J1 takes pairs 0..4, misses, J2 takes pairs 5..7
    do_reset();
    for (int p = 0; p < 5; p++) begin
      play(4'(2*p), 4'(p), 4'(2*p+1), 4'(p));
      @(negedge clk);
    end
    check("g_j1_five",   16'(score_j1), 16'd5);
    check("g_matched5",  matched_mask, 16'h03FF);
    check("g_player_j1", 16'(player), 16'd0);
    // Held sel_valid: two consecutive high cycles are two selections
    sel_valid = 1'b1;
    sel_idx = 4'd10; sel_label = 4'd5;
    @(negedge clk);
    sel_idx = 4'd12; sel_label = 4'd6;
    @(negedge clk);
    sel_valid = 1'b0;
    check("held_reveal", reveal_mask, 16'h1400);
    repeat (4) @(negedge clk);
    check("g_miss_player", 16'(player), 16'd1);
    @(negedge clk);
    for (int p = 5; p < 8; p++) begin
      play(4'(2*p), 4'(p), 4'(2*p+1), 4'(p));
      if (p < 7) @(negedge clk);
    end
    check("g_last_res",     16'(res_valid), 16'd1);
    check("g_last_nofin",   16'(finish), 16'd0);
    @(negedge clk);
    check("g_finish",       16'(finish), 16'd1);
    check("g_done_busy",    16'(busy), 16'd1);
    pick(4'd0, 4'd0);
    check("g_done_reveal",  reveal_mask, 16'h0000);
    check("g_done_scores",  {8'd0, score_j1, score_j2}, 16'h0053);
    check("g_done_matched", matched_mask, 16'hFFFF);
    check("g_done_finish",  16'(finish), 16'd1);

    // Reset in the third SHOW cycle, with a selection presented during reset
    do_reset();
    play(4'd0, 4'd1, 4'd1, 4'd3);
    @(negedge clk);
    do_reset();
    pick(4'd2, 4'd4);
    pick(4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sel_valid = 1'b1; sel_idx = 4'd4; sel_label = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    sel_valid = 1'b0;
    check("r_reveal",  reveal_mask, 16'h0000);
    check("r_matched", matched_mask, 16'h0000);
    check("r_busy",    16'(busy), 16'd0);
    check("r_res",     {14'd0, res_valid, res_match}, 16'h0000);
    check("r_player",  16'(player), 16'd0);
    check("r_scores",  {8'd0, score_j1, score_j2}, 16'h0000);
    check("r_finish",  16'(finish), 16'd0);
    play(4'd4, 4'd0, 4'd9, 4'd0);
    check("r_fresh_res",   16'(res_valid), 16'd1);
    check("r_fresh_match", matched_mask, 16'h0210);
    check("r_fresh_score", 16'(score_j1), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
